// File: rtl/calc_defs_pkg.sv
// Shared calculator definitions: operator encodings, entry FSM states and LED patterns.
// Used by the key entry front end, the ALU and the display block.
package calc_defs_pkg;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    typedef enum logic [2:0] {
        S_A,
        S_OP,
        S_B,
        S_REQ,
        S_SHOW
    } state_t;

    localparam logic [2:0] LED_A    = 3'b001;
    localparam logic [2:0] LED_OP   = 3'b011;
    localparam logic [2:0] LED_B    = 3'b010;
    localparam logic [2:0] LED_REQ  = 3'b010;
    localparam logic [2:0] LED_SHOW = 3'b101;

    // Several operator buttons landing together: the lowest index wins.
    function automatic logic [1:0] encode_op(input logic [3:0] hits);
        if (hits[0])      return OP_ADD;
        else if (hits[1]) return OP_SUB;
        else if (hits[2]) return OP_MUL;
        else              return OP_DIV;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stable-level debouncer and
// one-cycle rising-edge pulse of the debounced level.
module btn_debounce #(
    parameter int DEB_CYC = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYC - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            rise  <= 1'b0;
            // Any cycle where the synced input agrees with the accepted level restarts the count.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level <= sync2;
                rise  <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/key_entry_ctrl.sv
// Calculator input front end: conditions the buttons, sequences A/op/B entry
// and hands one calculation request at a time to the ALU over calc_req/calc_ack.
module key_entry_ctrl #(
    parameter int W       = 4,
    parameter int DEB_CYC = 50000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_number,
    input  logic [3:0]   arif,
    input  logic [1:0]   key,
    output logic [W-1:0] reg_a,
    output logic [W-1:0] reg_b,
    output logic [1:0]   op_code,
    output logic         calc_req,
    input  logic         calc_ack,
    output logic         err,
    output logic [2:0]   led
);

    import calc_defs_pkg::*;

    logic [W-1:0] num_s1;
    logic [W-1:0] num_s2;
    logic [5:0]   btn_raw;
    logic [5:0]   btn_rise;
    logic [5:0]   btn_level_unused;
    logic [3:0]   arif_ev;
    logic         enter_ev;
    logic         clear_ev;

    state_t       state,    state_n;
    logic [W-1:0] reg_a_n,  reg_b_n;
    logic [1:0]   op_code_n;
    logic         calc_req_n;
    logic         err_n;

    assign btn_raw  = {key, arif};
    assign arif_ev  = btn_rise[3:0];
    assign enter_ev = btn_rise[4];
    assign clear_ev = btn_rise[5];

    for (genvar i = 0; i < 6; i++) begin : g_btn
        btn_debounce #(.DEB_CYC(DEB_CYC)) u_btn (
            .clk   (clk),
            .rst   (rst),
            .raw   (btn_raw[i]),
            .level (btn_level_unused[i]),
            .rise  (btn_rise[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            num_s1 <= '0;
            num_s2 <= '0;
        end else begin
            num_s1 <= in_number;
            num_s2 <= num_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_A;
            reg_a    <= '0;
            reg_b    <= '0;
            op_code  <= OP_ADD;
            calc_req <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            reg_a    <= reg_a_n;
            reg_b    <= reg_b_n;
            op_code  <= op_code_n;
            calc_req <= calc_req_n;
            err      <= err_n;
        end
    end

    always_comb begin
        state_n    = state;
        reg_a_n    = reg_a;
        reg_b_n    = reg_b;
        op_code_n  = op_code;
        calc_req_n = calc_req;
        err_n      = err;
        // Clear overrides whatever else arrived in the same cycle.
        if (clear_ev) begin
            state_n    = S_A;
            reg_a_n    = '0;
            reg_b_n    = '0;
            op_code_n  = OP_ADD;
            calc_req_n = 1'b0;
            err_n      = 1'b0;
        end else begin
            case (state)
                S_A: if (enter_ev) begin
                    reg_a_n = num_s2;
                    err_n   = 1'b0;
                    state_n = S_OP;
                end
                S_OP: if (|arif_ev) begin
                    op_code_n = encode_op(arif_ev);
                    state_n   = S_B;
                end
                S_B: if (enter_ev) begin
                    reg_b_n = num_s2;
                    if (op_code == OP_DIV && num_s2 == '0) begin
                        err_n   = 1'b1;
                        state_n = S_SHOW;
                    end else begin
                        calc_req_n = 1'b1;
                        state_n    = S_REQ;
                    end
                end
                S_REQ: if (calc_ack) begin
                    calc_req_n = 1'b0;
                    state_n    = S_SHOW;
                end
                S_SHOW: if (enter_ev) begin
                    state_n = S_A;
                end
                default: state_n = S_A;
            endcase
        end
    end

    always_comb begin
        led = LED_A;
        case (state)
            S_A:     led = LED_A;
            S_OP:    led = LED_OP;
            S_B:     led = LED_B;
            S_REQ:   led = LED_REQ;
            S_SHOW:  led = LED_SHOW;
            default: led = LED_A;
        endcase
    end

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Self-checking bench for key_entry_ctrl (DEB_CYC=4): directed scenarios plus randomized
// entry sequences compared against an event-level reference model.
module tb_key_entry_ctrl;

    localparam int W   = 4;
    localparam int DEB = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_number;
    logic [3:0]   arif;
    logic [1:0]   key;
    logic [W-1:0] reg_a;
    logic [W-1:0] reg_b;
    logic [1:0]   op_code;
    logic         calc_req;
    logic         calc_ack;
    logic         err;
    logic [2:0]   led;

    int cmp_count  = 0;
    int fail_count = 0;
    int req_cycles = 0;

    // Reference model: phase 0=A, 1=OP, 2=B, 3=REQ, 4=SHOW
    int           m_phase;
    logic [W-1:0] m_a, m_b;
    logic [1:0]   m_op;
    logic         m_err, m_req;

    always #5 clk = ~clk;

    always @(negedge clk) req_cycles <= req_cycles + (calc_req ? 1 : 0);

    key_entry_ctrl #(.W(W), .DEB_CYC(DEB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_number (in_number),
        .arif      (arif),
        .key       (key),
        .reg_a     (reg_a),
        .reg_b     (reg_b),
        .op_code   (op_code),
        .calc_req  (calc_req),
        .calc_ack  (calc_ack),
        .err       (err),
        .led       (led)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        cmp_count++;
        assert (got === exp) else begin
            fail_count++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] led_of(input int ph);
        case (ph)
            0: return 3'b001;
            1: return 3'b011;
            2: return 3'b010;
            3: return 3'b010;
            default: return 3'b101;
        endcase
    endfunction

    task automatic m_reset();
        m_phase = 0; m_a = '0; m_b = '0; m_op = 2'd0; m_err = 1'b0; m_req = 1'b0;
    endtask

    task automatic m_enter(input logic [W-1:0] v);
        if (m_phase == 0) begin
            m_a = v; m_err = 1'b0; m_phase = 1;
        end else if (m_phase == 2) begin
            m_b = v;
            if (m_op == 2'd3 && v == 0) begin
                m_err = 1'b1; m_phase = 4;
            end else begin
                m_req = 1'b1; m_phase = 3;
            end
        end else if (m_phase == 4) begin
            m_phase = 0;
        end
    endtask

    task automatic m_arif(input logic [3:0] vec);
        logic found;
        found = 1'b0;
        if (m_phase == 1 && vec != 0) begin
            for (int i = 0; i < 4; i++)
                if (vec[i] && !found) begin
                    m_op = 2'(i);
                    found = 1'b1;
                end
            m_phase = 2;
        end
    endtask

    task automatic m_clear();
        m_reset();
    endtask

    task automatic m_ack();
        if (m_phase == 3) begin
            m_req = 1'b0; m_phase = 4;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".led"},      8'(led),      8'(led_of(m_phase)));
        check({tag, ".reg_a"},    8'(reg_a),    8'(m_a));
        check({tag, ".reg_b"},    8'(reg_b),    8'(m_b));
        check({tag, ".op_code"},  8'(op_code),  8'(m_op));
        check({tag, ".err"},      8'(err),      8'(m_err));
        check({tag, ".calc_req"}, 8'(calc_req), 8'(m_req));
    endtask

    // Hold the buttons long enough to debounce, then release and let the release settle.
    task automatic press(input logic [3:0] a, input logic [1:0] k);
        arif = a; key = k;
        tick(12);
        arif = '0; key = '0;
        tick(12);
    endtask

    task automatic set_num(input logic [W-1:0] v);
        in_number = v;
        tick(3);
    endtask

    int snap;
    logic [W-1:0] rv;
    logic [3:0]   rvec;
    logic         ack_pre;
    int           clear_at;

    initial begin
        rst = 1'b1; in_number = '0; arif = '0; key = '0; calc_ack = 1'b0;
        m_reset();
        tick(2);
        check_model("reset");
        rst = 1'b0;
        tick(1);

        // Full add with exact pin-to-action latency
        set_num(4'd5);
        key = 2'b01;
        tick(DEB + 2);
        check("lat_pre.led", 8'(led), 8'(3'b001));
        tick(1);
        check("lat_edge.led", 8'(led), 8'(3'b011));
        check("lat_edge.reg_a", 8'(reg_a), 8'd5);
        key = '0;
        tick(12);
        m_enter(4'd5);
        press(4'b0001, 2'b00); m_arif(4'b0001);
        set_num(4'd3);
        press(4'b0000, 2'b01); m_enter(4'd3);
        check_model("add_req");
        tick(3);
        check("add_hold.calc_req", 8'(calc_req), 8'd1);
        calc_ack = 1'b1;
        tick(1);
        calc_ack = 1'b0;
        m_ack();
        check_model("add_done");

        // Ack outside the request phase is ignored
        calc_ack = 1'b1; tick(2); calc_ack = 1'b0; tick(1);
        check_model("ack_ignored");

        // Bounce on enter while showing the result
        for (int i = 0; i < 10; i++) begin
            key[0] = ~key[0];
            tick(2);
        end
        tick(2);
        check("bounce_quiet.led", 8'(led), 8'(3'b101));
        key[0] = 1'b1;
        tick(DEB + 2);
        check("bounce_pre.led", 8'(led), 8'(3'b101));
        tick(1);
        m_enter(in_number);
        check_model("bounce_edge");
        tick(100);
        check_model("bounce_held");
        key = '0;
        tick(12);

        // Division by zero
        set_num(4'd7);
        press(4'b0000, 2'b01); m_enter(4'd7);
        press(4'b1000, 2'b00); m_arif(4'b1000);
        set_num(4'd0);
        snap = req_cycles;
        press(4'b0000, 2'b01); m_enter(4'd0);
        check_model("div0");
        check("div0.req_cycles", 8'(req_cycles - snap), 8'd0);

        // Clear beats a same-cycle enter in S_B
        press(4'b0000, 2'b01); m_enter(in_number);
        set_num(4'd9);
        press(4'b0000, 2'b01); m_enter(4'd9);
        press(4'b0100, 2'b00); m_arif(4'b0100);
        check_model("prio_pre");
        set_num(4'd2);
        snap = req_cycles;
        press(4'b0000, 2'b11); m_clear();
        check_model("prio");
        check("prio.req_cycles", 8'(req_cycles - snap), 8'd0);

        // Operator press in S_A ignored; multi-bit operator resolves to lowest index
        press(4'b0010, 2'b00); m_arif(4'b0010);
        check_model("arif_in_a");
        set_num(4'd4);
        press(4'b0000, 2'b01); m_enter(4'd4);
        press(4'b0110, 2'b00); m_arif(4'b0110);
        check_model("arif_multi");

        // Reset in the middle of a request
        set_num(4'd1);
        press(4'b0000, 2'b01); m_enter(4'd1);
        check_model("rst_req_pre");
        rst = 1'b1; tick(1); rst = 1'b0;
        m_reset();
        check_model("rst_req");

        // Reset in the middle of a debounce
        key = 2'b01;
        tick(3);
        rst = 1'b1; tick(1); rst = 1'b0;
        key = '0;
        tick(15);
        check_model("rst_deb");

        // Randomized entry sequences
        for (int it = 0; it < 24; it++) begin
            clear_at = $urandom_range(0, 6);
            for (int step = 0; step < 5; step++) begin
                if (clear_at == step) begin
                    press(4'b0000, 2'b10); m_clear();
                end
                case (step)
                    0: begin
                        rv = 4'($urandom_range(0, 15));
                        set_num(rv);
                        press(4'b0000, 2'b01); m_enter(rv);
                    end
                    1: begin
                        rvec = 4'($urandom_range(1, 15));
                        press(rvec, 2'b00); m_arif(rvec);
                    end
                    2: begin
                        rv = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                        ack_pre = 1'($urandom_range(0, 1));
                        calc_ack = ack_pre;
                        set_num(rv);
                        press(4'b0000, 2'b01);
                        calc_ack = 1'b0;
                        m_enter(rv);
                        if (ack_pre) m_ack();
                    end
                    3: begin
                        if (m_phase == 3) begin
                            tick($urandom_range(0, 4));
                            check("rnd_hold.calc_req", 8'(calc_req), 8'd1);
                        end
                        calc_ack = 1'b1;
                        tick(1);
                        calc_ack = 1'b0;
                        m_ack();
                    end
                    default: begin
                        press(4'b0000, 2'b01); m_enter(in_number);
                    end
                endcase
                check_model("rnd");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule
